// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver: double-buffered 16-bit hex value,
// synchronised digit index, anti-ghosting blanking and leading-zero blanking.
//
// Ports:
//   clock, reset      system clock (posedge), asynchronous active-high reset
//   refreshcounter    2-bit digit index, asynchronous to clock
//   value_in, load    value to display and its load strobe
//   load_ready        high while the pending buffer is empty
//   suppress_lz       blank leading zero digits (digit 0 is always lit)
//   anode, segment    active-low digit enables and segments (a = bit 0)
//   frame_done        one-cycle pulse on each 3 -> 0 digit transition
//
// Optional feature macro SEVEN_SEG_DP_EN adds dp_in[3:0] (per-digit decimal
// point, buffered with value_in) and dp (active-low decimal point output).

module seven_seg_scan_driver #(
  parameter int BLANK_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  refreshcounter,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        load_ready,
  input  logic        suppress_lz,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        frame_done
`ifdef SEVEN_SEG_DP_EN
  ,
  input  logic [3:0]  dp_in,
  output logic        dp
`endif
);

  localparam int CW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  logic [1:0]    sync_q [SYNC_STAGES];
  logic [1:0]    sel;
  logic [1:0]    sel_prev_q;
  logic [1:0]    sel_show_q;
  logic          chg;
  logic          chg_q;
  logic          boundary;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [15:0]   active_q;
  logic [15:0]   pending_q;
  logic          pend_vld_q;

`ifdef SEVEN_SEG_DP_EN
  logic [3:0]    dp_act_q;
  logic [3:0]    dp_pend_q;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Digit k is a leading zero when every nibble from k upwards is zero.
  function automatic logic lz_blank(
    input logic [15:0] v,
    input logic [1:0]  k
  );
    logic b;
    b = 1'b0;
    case (k)
      2'd1:    b = (v[15:4] == 12'h000);
      2'd2:    b = (v[15:8] == 8'h00);
      2'd3:    b = (v[15:12] == 4'h0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Digit index synchroniser and change detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 2'd0;
      end
    end else begin
      sync_q[0] <= refreshcounter;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sel      = sync_q[SYNC_STAGES-1];
  assign chg      = (sel != sel_prev_q);
  assign boundary = chg && (sel_prev_q == 2'd3) && (sel == 2'd0);

  // sel_show_q lags sel_prev_q so the new index is only used on the same
  // edge the FSM enters BLANK; the old digit never sees the new index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_prev_q <= 2'd0;
      sel_show_q <= 2'd0;
      chg_q      <= 1'b0;
    end else begin
      sel_prev_q <= sel;
      sel_show_q <= sel_prev_q;
      chg_q      <= chg;
    end
  end

  // Display FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= BLANK_LD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter reaches SHOW after exactly BLANK_CYCLES cycles in BLANK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (chg_q) begin
      cnt_d   = BLANK_LD;
      state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q <= CW'(1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_SHOW: state_d = ST_SHOW;
      endcase
    end
  end

  // Double buffer: promotion at a frame boundary wins over a new load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q   <= 16'h0000;
      pending_q  <= 16'h0000;
      pend_vld_q <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
      dp_act_q   <= 4'h0;
      dp_pend_q  <= 4'h0;
`endif
    end else if (boundary && pend_vld_q) begin
      active_q   <= pending_q;
      pend_vld_q <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
      dp_act_q   <= dp_pend_q;
`endif
    end else if (load && !pend_vld_q) begin
      pending_q  <= value_in;
      pend_vld_q <= 1'b1;
`ifdef SEVEN_SEG_DP_EN
      dp_pend_q  <= dp_in;
`endif
    end
  end

  assign load_ready = !pend_vld_q;
  assign frame_done = boundary;

  always_comb begin
    anode   = 4'hF;
    segment = 7'h7F;
    if (state_q == ST_SHOW) begin
      anode = ~(4'b0001 << sel_show_q);
      if (!(suppress_lz && lz_blank(active_q, sel_show_q))) begin
        segment = seg_decode(active_q[4*sel_show_q +: 4]);
      end
    end
  end

`ifdef SEVEN_SEG_DP_EN
  always_comb begin
    dp = 1'b1;
    if (state_q == ST_SHOW) begin
      dp = ~dp_act_q[sel_show_q];
    end
  end
`endif

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: directed scenarios plus a
// randomized scan/load sequence against an event-level display model.

module tb_seven_seg_scan_driver;

  localparam int BLANK = 16;
  localparam int SYNC  = 2;
  localparam int T_FD  = SYNC - 1;
  localparam int T_PR  = SYNC;
  localparam int T_BL  = SYNC + 1;
  localparam int T_SH  = SYNC + 1 + BLANK;

  logic        clock;
  logic        reset;
  logic [1:0]  refreshcounter;
  logic [15:0] value_in;
  logic        load;
  logic        load_ready;
  logic        suppress_lz;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        frame_done;
`ifdef SEVEN_SEG_DP_EN
  logic [3:0]  dp_in;
  logic        dp;
  logic [3:0]  ld_dp;
  logic [3:0]  m_dp_act;
  logic [3:0]  m_dp_pend;
  logic        exp_dp;
`endif

  int vectors = 0;
  int errs    = 0;

  logic [15:0] m_active;
  logic [15:0] m_pend;
  logic        m_pv;
  logic [1:0]  cur;

  logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seven_seg_scan_driver #(
    .BLANK_CYCLES(BLANK),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .refreshcounter(refreshcounter),
    .value_in      (value_in),
    .load          (load),
    .load_ready    (load_ready),
    .suppress_lz   (suppress_lz),
    .anode         (anode),
    .segment       (segment),
    .frame_done    (frame_done)
`ifdef SEVEN_SEG_DP_EN
    ,
    .dp_in         (dp_in),
    .dp            (dp)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] exp_seg(
    input logic [15:0] act,
    input logic [1:0]  d,
    input logic        slz
  );
    int k;
    k = int'(d);
    if (slz && k != 0 && (act >> (4 * k)) == 0) return 7'h7F;
    return DEC[(act >> (4 * k)) & 16'hF];
  endfunction

  // Move to digit d and follow the display for hold cycles.
  task automatic scan_to(input logic [1:0] d, input int hold);
    logic       bnd;
    logic       efd;
    logic [3:0] ea;
    logic [6:0] es;
    bnd = (cur == 2'd3) && (d == 2'd0);
    @(posedge clock); #1;
    refreshcounter = d;
    for (int k = 0; k <= hold; k++) begin
      @(posedge clock); #1;
      if (k == T_PR && bnd && m_pv) begin
        m_active = m_pend;
        m_pv = 1'b0;
`ifdef SEVEN_SEG_DP_EN
        m_dp_act = m_dp_pend;
`endif
      end
      efd = (k == T_FD) && bnd;
      vectors++;
      if (frame_done !== efd) begin
        errs++;
        $display("FAIL frame_done d=%0d k=%0d got %b want %b",
                 d, k, frame_done, efd);
      end
      vectors++;
      if (load_ready !== !m_pv) begin
        errs++;
        $display("FAIL load_ready d=%0d k=%0d got %b want %b",
                 d, k, load_ready, !m_pv);
      end
      if (k >= T_BL) begin
        if (k < T_SH) begin
          ea = 4'hF;
          es = 7'h7F;
        end else begin
          ea = ~(4'b0001 << d);
          es = exp_seg(m_active, d, suppress_lz);
        end
        vectors++;
        if (anode !== ea) begin
          errs++;
          $display("FAIL anode d=%0d k=%0d got %b want %b",
                   d, k, anode, ea);
        end
        vectors++;
        if (segment !== es) begin
          errs++;
          $display("FAIL segment d=%0d k=%0d act=%h got %h want %h",
                   d, k, m_active, segment, es);
        end
`ifdef SEVEN_SEG_DP_EN
        exp_dp = (k < T_SH) ? 1'b1 : ~m_dp_act[d];
        vectors++;
        if (dp !== exp_dp) begin
          errs++;
          $display("FAIL dp d=%0d k=%0d got %b want %b", d, k, dp, exp_dp);
        end
`endif
      end
    end
    cur = d;
  endtask

  task automatic do_load(input logic [15:0] v);
    vectors++;
    if (load_ready !== !m_pv) begin
      errs++;
      $display("FAIL load_ready_pre got %b want %b", load_ready, !m_pv);
    end
    value_in = v;
`ifdef SEVEN_SEG_DP_EN
    dp_in = ld_dp;
`endif
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    if (!m_pv) begin
      m_pend = v;
      m_pv = 1'b1;
`ifdef SEVEN_SEG_DP_EN
      m_dp_pend = ld_dp;
`endif
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (anode !== 4'hF) begin
      errs++;
      $display("FAIL rst_anode got %h want F", anode);
    end
    vectors++;
    if (segment !== 7'h7F) begin
      errs++;
      $display("FAIL rst_segment got %h want 7F", segment);
    end
    vectors++;
    if (frame_done !== 1'b0 || load_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_flags got fd=%b lr=%b want 0 1",
               frame_done, load_ready);
    end
    #20;
    reset = 1'b0;
    repeat (BLANK + 4) @(posedge clock);
    #1;
    vectors++;
    if (anode !== 4'b1110 || segment !== 7'h40) begin
      errs++;
      $display("FAIL rst_show got %b/%h want 1110/40", anode, segment);
    end
  endtask

  task automatic test_basic();
    do_load(16'h1234);
    scan_to(2'd1, 24);
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
    scan_to(2'd0, 24);
    vectors++;
    if (anode !== 4'b1110 || segment !== 7'h19) begin
      errs++;
      $display("FAIL basic_d0 got %b/%h want 1110/19", anode, segment);
    end
    scan_to(2'd1, 24);
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
    vectors++;
    if (anode !== 4'b0111 || segment !== 7'h79) begin
      errs++;
      $display("FAIL basic_d3 got %b/%h want 0111/79", anode, segment);
    end
    scan_to(2'd0, 24);
  endtask

  task automatic test_blanking();
    scan_to(2'd1, 26);
    vectors++;
    if (anode !== 4'b1101) begin
      errs++;
      $display("FAIL blank_end got %b want 1101", anode);
    end
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
  endtask

  task automatic test_load_ignore();
    do_load(16'h00AB);
    do_load(16'hFFFF);
    scan_to(2'd0, 24);
    vectors++;
    if (segment !== 7'h03 || load_ready !== 1'b1) begin
      errs++;
      $display("FAIL ignore_d0 got %h lr=%b want 03 1", segment, load_ready);
    end
    scan_to(2'd1, 24);
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
  endtask

  task automatic test_suppress();
    suppress_lz = 1'b1;
    do_load(16'h0050);
    scan_to(2'd0, 24);
    scan_to(2'd1, 24);
    vectors++;
    if (segment !== 7'h12) begin
      errs++;
      $display("FAIL lz_d1 got %h want 12", segment);
    end
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
    vectors++;
    if (anode !== 4'b0111 || segment !== 7'h7F) begin
      errs++;
      $display("FAIL lz_d3 got %b/%h want 0111/7F", anode, segment);
    end
    do_load(16'h0000);
    scan_to(2'd0, 24);
    vectors++;
    if (segment !== 7'h40) begin
      errs++;
      $display("FAIL lz_zero got %h want 40", segment);
    end
    scan_to(2'd1, 24);
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
    suppress_lz = 1'b0;
    #1;
    vectors++;
    if (segment !== 7'h40) begin
      errs++;
      $display("FAIL lz_live got %h want 40", segment);
    end
  endtask

  task automatic test_back_to_back();
    do_load(16'hC0DE);
    scan_to(2'd0, 6);
    scan_to(2'd2, 6);
    scan_to(2'd3, 8);
    scan_to(2'd0, 24);
    scan_to(2'd1, 24);
  endtask

  task automatic test_reset_mid();
    do_load(16'h9876);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (anode !== 4'hF || segment !== 7'h7F || load_ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_rst got %h/%h lr=%b want F/7F 1",
               anode, segment, load_ready);
    end
    refreshcounter = 2'd0;
    m_active = 16'h0000;
    m_pv = 1'b0;
`ifdef SEVEN_SEG_DP_EN
    m_dp_act = 4'h0;
    vectors++;
    if (dp !== 1'b1) begin
      errs++;
      $display("FAIL mid_rst_dp got %b want 1", dp);
    end
`endif
    cur = 2'd0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    repeat (BLANK + 4) @(posedge clock);
    #1;
    vectors++;
    if (anode !== 4'b1110 || segment !== 7'h40) begin
      errs++;
      $display("FAIL mid_rst_show got %b/%h want 1110/40", anode, segment);
    end
    scan_to(2'd1, 24);
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
    scan_to(2'd0, 24);
  endtask

`ifdef SEVEN_SEG_DP_EN
  task automatic test_dp();
    ld_dp = 4'b0100;
    do_load(16'h1234);
    scan_to(2'd1, 24);
    scan_to(2'd2, 24);
    scan_to(2'd3, 24);
    scan_to(2'd0, 24);
    scan_to(2'd1, 24);
    scan_to(2'd2, 24);
    vectors++;
    if (dp !== 1'b0) begin
      errs++;
      $display("FAIL dp_d2 got %b want 0", dp);
    end
    scan_to(2'd3, 24);
  endtask
`endif

  task automatic test_random();
    logic [1:0] d;
    int         hold;
    for (int i = 0; i < 48; i++) begin
      d = 2'($urandom_range(0, 3));
      if (d == cur) d = d + 2'd1;
      if (i % 6 == 5) d = (cur == 2'd3) ? 2'd0 : cur + 2'd1;
      suppress_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
`ifdef SEVEN_SEG_DP_EN
        ld_dp = 4'($urandom);
`endif
        do_load(16'($urandom));
      end
      hold = ($urandom_range(0, 4) == 0) ? 4 + $urandom_range(0, 10)
                                         : T_SH + $urandom_range(0, 4);
      scan_to(d, hold);
    end
  endtask

  initial begin
    reset = 1'b1;
    refreshcounter = 2'd0;
    value_in = 16'h0000;
    load = 1'b0;
    suppress_lz = 1'b0;
    m_active = 16'h0000;
    m_pend = 16'h0000;
    m_pv = 1'b0;
    cur = 2'd0;
`ifdef SEVEN_SEG_DP_EN
    dp_in = 4'h0;
    ld_dp = 4'h0;
    m_dp_act = 4'h0;
    m_dp_pend = 4'h0;
`endif
    test_reset();
    test_basic();
    test_blanking();
    test_load_ignore();
    test_suppress();
    test_back_to_back();
    test_reset_mid();
`ifdef SEVEN_SEG_DP_EN
    test_dp();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
